n1_seq_ctrl: RTL and testbench

//  Fetch/execute sequencer for the n1 core. Owns the single-port synchronous program/data RAM and drives it for both the core and a host loader.

---
 rtl/n1_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_n1_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n1_seq_ctrl.sv
// Fetch/execute sequencer for the n1 core: owns PC, accumulator r0 and the
// single RAM port, which it time-shares with a host loader at instruction boundaries.
`timescale 1ns/1ps

module n1_seq_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              resume,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              halted,
    output logic              busy
);

    localparam int OPC_LSB = DATA_W - 3;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b010;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HOST,
        S_HACK,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic                halted_q, halted_d;
    logic                hwe_q, hwe_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;

    logic [2:0]          opcode;
    logic [ADDR_W-1:0]   inst_addr;
    state_t              boundary_next;

    assign opcode    = inst_q[DATA_W-1:OPC_LSB];
    assign inst_addr = inst_q[ADDR_W-1:0];

    // Host has priority so a loader can never be starved by a running program.
    always_comb begin
        if (host_req) begin
            boundary_next = S_HOST;
        end else if (halted_q) begin
            boundary_next = S_HALT;
        end else if (run) begin
            boundary_next = S_FETCH;
        end else begin
            boundary_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            acc_q    <= '0;
            inst_q   <= '0;
            halted_q <= 1'b0;
            hwe_q    <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            inst_q   <= inst_d;
            halted_q <= halted_d;
            hwe_q    <= hwe_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        inst_d   = inst_q;
        halted_d = halted_q;
        hwe_d    = hwe_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;

        case (state_q)
            S_IDLE: begin
                state_d = boundary_next;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                inst_d  = ram_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD:  state_d = S_WB;
                    OP_JMP: begin
                        pc_d    = inst_addr;
                        state_d = boundary_next;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default:  state_d = boundary_next;
                endcase
            end
            S_WB: begin
                acc_d   = ram_rdata;
                state_d = boundary_next;
            end
            S_HOST: begin
                state_d = S_HACK;
            end
            S_HACK: begin
                state_d = boundary_next;
            end
            S_HALT: begin
                // A simultaneous resume is dropped when the host wins this cycle.
                if (host_req) begin
                    state_d = S_HOST;
                end else if (resume) begin
                    halted_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Latch the host request when it is granted so the HOST cycle is a pure
        // function of registered state.
        if (state_d == S_HOST) begin
            hwe_d    = host_we;
            haddr_d  = host_addr;
            hwdata_d = host_wdata;
        end
    end

    always_comb begin
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        host_ack   = 1'b0;
        host_rdata = '0;

        case (state_q)
            S_FETCH: begin
                ram_en   = 1'b1;
                ram_addr = pc_q;
            end
            S_EXEC: begin
                if (opcode == OP_LOAD) begin
                    ram_en   = 1'b1;
                    ram_addr = inst_addr;
                end else if (opcode == OP_STORE) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = inst_addr;
                    ram_wdata = acc_q;
                end
            end
            S_HOST: begin
                ram_en    = 1'b1;
                ram_we    = hwe_q;
                ram_addr  = haddr_q;
                ram_wdata = hwdata_q;
            end
            S_HACK: begin
                host_ack   = 1'b1;
                host_rdata = ram_rdata;
            end
            default: begin
            end
        endcase
    end

    assign pc     = pc_q;
    assign acc    = acc_q;
    assign halted = halted_q;
    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_n1_seq_ctrl.sv
// Self-checking bench for n1_seq_ctrl: behavioural RAM, table-driven host
// accesses with a read-data scoreboard, and hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_n1_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       resume = 1'b0;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [4:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       ram_en;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic [4:0] pc;
    logic [7:0] acc;
    logic       halted;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] mem [0:31];
    logic [7:0] rd_exp_q [$];
    logic [4:0] fetch_q [$];

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } hvec_t;

    typedef struct {
        logic       en;
        logic       we;
        logic [4:0] addr;
        logic       ack;
    } cyc_t;

    always #5 clk = ~clk;

    n1_seq_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .resume(resume),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .pc(pc), .acc(acc), .halted(halted), .busy(busy)
    );

    // Single-port synchronous RAM with registered read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; resume = 1'b0; host_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called just after a negedge; returns just after the negedge following the ack.
    task automatic host_op(input logic we, input logic [4:0] a, input logic [7:0] d,
                           input logic [7:0] exp);
        int cyc;
        logic [7:0] e;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        if (!we) rd_exp_q.push_back(exp);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (host_ack) break;
        end
        check("host_latency", cyc, 2);
        $display("host %s addr=%0d wdata=%02h rdata=%02h ack_after=%0d",
                 we ? "wr" : "rd", a, d, host_rdata, cyc);
        if (!we && rd_exp_q.size() > 0) begin
            e = rd_exp_q.pop_front();
            check("host_rdata", host_rdata, e);
        end
        host_req = 1'b0;
        @(negedge clk);
        check("host_ack_one_cycle", host_ack, 0);
    endtask

    task automatic wait_ram_en(output int cyc);
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ram_en) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        hvec_t tbl [6];
        cyc_t  seq4 [5];
        int    cnt;
        int    it;
        logic [4:0] fa;

        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        // Reset state, sampled while rst is still asserted.
        @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_acc", acc, 0);
        check("rst_halted", halted, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_host_ack", host_ack, 0);
        rst = 1'b0;

        // Test 1: load a tiny program over the host port, then run it.
        tbl[0] = '{1'b1, 5'd0,  8'h1F, 8'h00};
        tbl[1] = '{1'b1, 5'd1,  8'h9E, 8'h00};
        tbl[2] = '{1'b1, 5'd2,  8'hE0, 8'h00};
        tbl[3] = '{1'b1, 5'd31, 8'hA5, 8'h00};
        tbl[4] = '{1'b0, 5'd0,  8'h00, 8'h1F};
        tbl[5] = '{1'b0, 5'd31, 8'h00, 8'hA5};
        for (int i = 0; i < 6; i++) host_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);

        run = 1'b1;
        wait_ram_en(cnt);
        check("t1_first_fetch_addr", ram_addr, 0);
        check("t1_busy_in_fetch", busy, 1);
        cnt = 0;
        while (!halted && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("t1_halt_cycles", cnt, 10);
        check("t1_acc", acc, 8'hA5);
        check("t1_pc", pc, 3);
        check("t1_mem30", mem[30], 8'hA5);
        check("t1_busy_halt", busy, 0);

        // Test 2: host read while halted; stays halted afterwards.
        host_op(1'b0, 5'd30, 8'h00, 8'hA5);
        check("t2_still_halted", halted, 1);

        // Test 3: PC wrap at 31 and JMP redirect.
        do_reset();
        host_op(1'b1, 5'd0,  8'h45, 8'h00);
        host_op(1'b1, 5'd5,  8'h43, 8'h00);
        host_op(1'b1, 5'd3,  8'h5F, 8'h00);
        host_op(1'b1, 5'd31, 8'h20, 8'h00);
        fetch_q.push_back(5'd0);
        fetch_q.push_back(5'd5);
        fetch_q.push_back(5'd3);
        fetch_q.push_back(5'd31);
        fetch_q.push_back(5'd0);
        run = 1'b1;
        it = 0;
        while (fetch_q.size() > 0 && it < 60) begin
            @(negedge clk);
            it++;
            if (ram_en && !ram_we) begin
                fa = fetch_q.pop_front();
                check("t3_fetch_addr", ram_addr, fa);
                $display("fetch addr=%0d pc=%0d", ram_addr, pc);
                if (fetch_q.size() == 0) begin
                    run = 1'b0;
                end else if (fa == 5'd31) begin
                    @(negedge clk);
                    check("t3_pc_in_decode", pc, 31);
                    @(negedge clk);
                    check("t3_pc_wrapped", pc, 0);
                end
            end
        end
        check("t3_fetches_left", fetch_q.size(), 0);
        cnt = 0;
        while (busy && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("t3_idle_after_run_low", busy, 0);
        check("t3_pc_after_jmp", pc, 5);

        // Test 4: host request raised during DECODE of a LOAD waits for WB.
        do_reset();
        host_op(1'b1, 5'd0,  8'h0A, 8'h00);
        host_op(1'b1, 5'd10, 8'h77, 8'h00);
        host_op(1'b1, 5'd20, 8'h33, 8'h00);
        host_op(1'b1, 5'd1,  8'hE0, 8'h00);
        seq4[0] = '{1'b1, 1'b0, 5'd10, 1'b0};
        seq4[1] = '{1'b0, 1'b0, 5'd0,  1'b0};
        seq4[2] = '{1'b1, 1'b0, 5'd20, 1'b0};
        seq4[3] = '{1'b0, 1'b0, 5'd0,  1'b1};
        seq4[4] = '{1'b1, 1'b0, 5'd1,  1'b0};
        run = 1'b1;
        wait_ram_en(cnt);
        check("t4_fetch0", ram_addr, 0);
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd20;
        rd_exp_q.push_back(8'h33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_ram_en", ram_en, seq4[i].en);
            check("t4_ram_we", ram_we, seq4[i].we);
            if (seq4[i].en) check("t4_ram_addr", ram_addr, seq4[i].addr);
            check("t4_host_ack", host_ack, seq4[i].ack);
            if (i == 2) check("t4_acc_after_wb", acc, 8'h77);
            if (seq4[i].ack) begin
                check("t4_host_rdata", host_rdata, rd_exp_q.pop_front());
                $display("host rd addr=20 rdata=%02h (mid-instruction request)", host_rdata);
                host_req = 1'b0;
            end
        end
        run = 1'b0;

        // Test 5: reset during STORE EXEC aborts the write.
        do_reset();
        host_op(1'b1, 5'd0,  8'h0A, 8'h00);
        host_op(1'b1, 5'd1,  8'h9E, 8'h00);
        host_op(1'b1, 5'd30, 8'h11, 8'h00);
        run = 1'b1;
        cnt = 0;
        while (cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (ram_en && ram_we) break;
        end
        check("t5_store_seen", ram_we, 1);
        check("t5_store_addr", ram_addr, 30);
        check("t5_acc_before_rst", acc, 8'h77);
        rst = 1'b1;
        #1;
        check("t5_rst_ram_we", ram_we, 0);
        check("t5_rst_ram_en", ram_en, 0);
        check("t5_rst_pc", pc, 0);
        check("t5_rst_acc", acc, 0);
        check("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        host_op(1'b0, 5'd30, 8'h00, 8'h11);

        // Test 6: resume coincident with host_req in HALT is lost.
        do_reset();
        host_op(1'b1, 5'd0, 8'hE0, 8'h00);
        run = 1'b1;
        cnt = 0;
        while (!halted && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("t6_halted", halted, 1);
        run = 1'b0;
        resume = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd7; host_wdata = 8'h5A;
        @(negedge clk);
        resume = 1'b0;
        check("t6_ack_early", host_ack, 0);
        @(negedge clk);
        check("t6_ack", host_ack, 1);
        $display("host wr addr=7 wdata=5a (with resume)");
        host_req = 1'b0;
        check("t6_halted_during_host", halted, 1);
        repeat (3) @(negedge clk);
        check("t6_halted_after_host", halted, 1);
        check("t6_mem7", mem[7], 8'h5A);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("t6_resumed", halted, 0);
        check("t6_idle", busy, 0);
        host_op(1'b0, 5'd7, 8'h00, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
